// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] AluBReg      = 2'b00;
  localparam logic [1:0] AluBFour     = 2'b01;
  localparam logic [1:0] AluBImm      = 2'b10;
  localparam logic [1:0] AluBImmShift = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current controller state to its datapath control word.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      StFetch: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = AluBFour;
        o_ctrl.alu_op    = AluOpAdd;
        o_ctrl.pc_source = PcSrcAlu;
        o_ctrl.pc_write  = 1'b1;
      end
      // Branch target is precomputed here while the opcode is decoded.
      StDecode: begin
        o_ctrl.alu_src_b = AluBImmShift;
        o_ctrl.alu_op    = AluOpAdd;
      end
      StMemAddr, StIExec: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = AluBImm;
        o_ctrl.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      StRExec: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = AluBReg;
        o_ctrl.alu_op    = AluOpFunct;
      end
      StRWb: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      StIWb: begin
        o_ctrl.reg_write = 1'b1;
      end
      StBranch: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = AluBReg;
        o_ctrl.alu_op        = AluOpSub;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PcSrcJump;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main control FSM: state register, opcode-driven sequencing and
// the registered illegal-opcode pulse.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_e r_state;
  state_e w_state_next;
  logic   r_illegal_op;
  logic   w_illegal_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StFetch;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_illegal_op <= w_illegal_next;
    end
  end

  always_comb begin
    w_state_next   = StFetch;
    w_illegal_next = 1'b0;
    unique case (r_state)
      StFetch: w_state_next = StDecode;
      // Any opcode not matched, including X/Z, falls to default and is flagged.
      StDecode: begin
        case (opcode)
          OpLw, OpSw: w_state_next = StMemAddr;
          OpRtype:    w_state_next = StRExec;
          OpAddi:     w_state_next = StIExec;
          OpBeq:      w_state_next = StBranch;
          OpJ:        w_state_next = StJump;
          default: begin
            w_state_next   = StFetch;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      StMemAddr: w_state_next = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   w_state_next = StMemWb;
      StRExec:   w_state_next = StRWb;
      StIExec:   w_state_next = StIWb;
      StMemWb, StMemWr, StRWb, StIWb, StBranch, StJump: w_state_next = StFetch;
      default:   w_state_next = StFetch;
    endcase
  end

  mc_ctrl_decode u_ctrl_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle comparison of every control output
// against hand-written expected control words.
module tb_mc_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int unsigned n_checks;
  int unsigned n_errors;

  // Expected-state tags used by the stimulus tables.
  localparam int SFetch = 0, SDecode = 1, SMemAddr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
  localparam int SRExec = 6, SRWb = 7, SIExec = 8, SIWb = 9, SBranch = 10, SJump = 11;
  localparam int SFetchIll = 12;

  mc_controller u_dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb[2], aop[2], psrc[2], ill}
  logic [16:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [16:0] exp_word(input int s);
    case (s)
      SFetch:    return 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
      SDecode:   return 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
      SMemAddr:  return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      SMemRd:    return 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
      SMemWb:    return 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
      SMemWr:    return 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
      SRExec:    return 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
      SRWb:      return 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
      SIExec:    return 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
      SIWb:      return 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
      SBranch:   return 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
      SJump:     return 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
      SFetchIll: return 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_1;
      default:   return 17'h0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at a negedge: check the current cycle, then advance one cycle.
  task automatic step(input string tag, input int s);
    check_eq(tag, obs, exp_word(s));
    @(negedge clk);
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input int len,
                           input int seq [5]);
    opcode = op;
    for (int i = 0; i < len; i++) step($sformatf("%s_c%0d", name, i + 1), seq[i]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    opcode   = 6'h00;
    repeat (2) @(negedge clk);
    check_eq("reset_held", obs, exp_word(SFetch));
    rst = 1'b0;

    // Start an R-type and abort it with reset in R_EXEC.
    opcode = 6'h00;
    step("abort_fetch", SFetch);
    step("abort_decode", SDecode);
    check_eq("abort_rexec", obs, exp_word(SRExec));
    rst = 1'b1;
    #1;
    check_eq("async_reset", obs, exp_word(SFetch));
    @(negedge clk);
    for (int i = 0; i < 3; i++) step($sformatf("rst_hold%0d", i), SFetch);
    rst = 1'b0;
    step("post_rst_fetch", SFetch);
    step("post_rst_decode", SDecode);
    step("post_rst_rexec", SRExec);
    step("post_rst_rwb", SRWb);

    run_instr("lw",   6'h23, 5, '{SFetch, SDecode, SMemAddr, SMemRd, SMemWb});
    run_instr("sw",   6'h2B, 4, '{SFetch, SDecode, SMemAddr, SMemWr, SFetch});
    run_instr("rt",   6'h00, 4, '{SFetch, SDecode, SRExec, SRWb, SFetch});
    run_instr("addi", 6'h08, 4, '{SFetch, SDecode, SIExec, SIWb, SFetch});
    run_instr("beq",  6'h04, 3, '{SFetch, SDecode, SBranch, SFetch, SFetch});
    run_instr("j",    6'h02, 3, '{SFetch, SDecode, SJump, SFetch, SFetch});
    run_instr("ill",  6'h3F, 2, '{SFetch, SDecode, SFetch, SFetch, SFetch});
    // FETCH after the illegal decode carries the one-cycle illegal_op pulse.
    run_instr("j_after_ill", 6'h02, 3, '{SFetchIll, SDecode, SJump, SFetch, SFetch});
    run_instr("ill2", 6'h01, 2, '{SFetch, SDecode, SFetch, SFetch, SFetch});
    run_instr("lw_after_ill", 6'h23, 5, '{SFetchIll, SDecode, SMemAddr, SMemRd, SMemWb});
    step("final_fetch", SFetch);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
